// File: rtl/restoring_divider_if.sv
// Operand/result bundle for the restoring divider.
// The operand latch / issue logic drives the master side; the divider is the
// slave. Clock and reset are kept as plain ports on the divider itself.
`timescale 1ns/1ps

interface restoring_divider_if #(
  parameter int N = 4
);

  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_quotient;
  logic [N-1:0] o_remainder;
  logic         o_divide_by_zero;

  modport master (
    output i_start,
    output i_dividend,
    output i_divisor,
    input  o_busy,
    input  o_done,
    input  o_quotient,
    input  o_remainder,
    input  o_divide_by_zero
  );

  modport slave (
    input  i_start,
    input  i_dividend,
    input  i_divisor,
    output o_busy,
    output o_done,
    output o_quotient,
    output o_remainder,
    output o_divide_by_zero
  );

endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider (DIV/MOD path of the ALU).
// One quotient bit is produced per clock by a single (N+1)-bit Subtractor
// that compares the shifted partial remainder with the divisor.
// Optional feature: define DIVIDER_ZERO_CHECK_EN to short-circuit a zero
// divisor straight to DONE and raise o_divide_by_zero; otherwise a zero
// divisor runs the normal N-cycle algorithm and the flag stays 0.
`timescale 1ns/1ps

module Subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuend_i,
  input  logic [W-1:0] subtrahend_i,
  output logic [W-1:0] difference_o,
  output logic         borrow_o
);

  // Widen by one bit so the top bit of the result is the borrow-out.
  assign {borrow_o, difference_o} = {1'b0, minuend_i} - {1'b0, subtrahend_i};

endmodule

module restoring_divider #(
  parameter int N = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  restoring_divider_if.slave     bus
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [N-1:0]  quotShift_q;
  logic [N-1:0]  partRem_q;
  logic [N-1:0]  divisor_q;
  logic [N-1:0]  quotient_q;
  logic [N-1:0]  remainder_q;
  logic          busy_q;
  logic          done_q;

  logic [N-1:0]  quotShift_d;
  logic [N-1:0]  partRem_d;

  logic [N:0]    trial;
  logic [N:0]    subtrahend;
  logic [N:0]    difference;
  logic          borrow;
  logic          unusedDiffMsb;

  // Trial value: partial remainder with the next dividend bit shifted in.
  assign trial      = {partRem_q, quotShift_q[N-1]};
  assign subtrahend = {1'b0, divisor_q};

  Subtractor #(
    .W (N + 1)
  ) u_subtractor (
    .minuend_i    (trial),
    .subtrahend_i (subtrahend),
    .difference_o (difference),
    .borrow_o     (borrow)
  );

  // While the algorithm runs the remainder stays below the divisor, so the
  // top difference bit is always zero whenever it is actually used.
  assign unusedDiffMsb = difference[N];

  // One restoring step: keep the difference if it fits, otherwise restore.
  always_comb begin
    partRem_d   = borrow ? trial[N-1:0] : difference[N-1:0];
    quotShift_d = {quotShift_q[N-2:0], ~borrow};
  end

`ifdef DIVIDER_ZERO_CHECK_EN
  logic divZero_q;
  logic divisorIsZero;

  assign divisorIsZero = (bus.i_divisor == '0);

  // Control FSM, datapath registers and registered results (zero-check build).
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      quotShift_q <= '0;
      partRem_q   <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.i_start) begin
            quotShift_q <= bus.i_dividend;
            divisor_q   <= bus.i_divisor;
            partRem_q   <= '0;
            count_q     <= '0;
            if (divisorIsZero) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= bus.i_dividend;
              divZero_q   <= 1'b1;
            end else begin
              state_q     <= RUN;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              quotient_q  <= '0;
              remainder_q <= '0;
              divZero_q   <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          partRem_q   <= partRem_d;
          quotShift_q <= quotShift_d;
          count_q     <= count_q + 1'b1;
          if (count_q == LAST) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= quotShift_d;
            remainder_q <= partRem_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_divide_by_zero = divZero_q;
`else
  // Control FSM, datapath registers and registered results.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      quotShift_q <= '0;
      partRem_q   <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.i_start) begin
            quotShift_q <= bus.i_dividend;
            divisor_q   <= bus.i_divisor;
            partRem_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            state_q     <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          partRem_q   <= partRem_d;
          quotShift_q <= quotShift_d;
          count_q     <= count_q + 1'b1;
          if (count_q == LAST) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= quotShift_d;
            remainder_q <= partRem_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_divide_by_zero = 1'b0;
`endif

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_quotient  = quotient_q;
  assign bus.o_remainder = remainder_q;

endmodule
